// File: rtl/div_seq_pkg.sv
// Shared state encoding and handshake constants for the multi-cycle divide sequencer.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the EX stage (master) and the divide sequencer (slave).
interface div_seq_if #(
  parameter int unsigned DATA_W = 32
);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/div_seq.sv
// Shift-subtract divider for DIV/DIVU: one quotient bit per cycle, {remainder, quotient} out,
// with a stall request held while a started divide has not yet produced its result.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic      Clk,
  input logic      Rst_n,
  div_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  div_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  signed_q, signed_d;
  logic                  neg_op1_q, neg_op1_d;
  logic                  neg_op2_q, neg_op2_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quot, rem;

  always_comb begin
    op1_abs = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    op2_abs = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // Trial subtraction of the divisor from the partial remainder; MSB set means it did not fit.
    diff = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

    quot = work_q[DATA_W-1:0];
    rem  = work_q[2*DATA_W:DATA_W+1];
    if (signed_q && (neg_op1_q ^ neg_op2_q)) quot = -quot;
    if (signed_q && neg_op1_q)               rem  = -rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    neg_op1_d = neg_op1_q;
    neg_op2_d = neg_op2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          signed_d  = bus.signed_div_i;
          neg_op1_d = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
          neg_op2_d = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
          divisor_d = op2_abs;
          work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          cnt_d     = '0;
          state_d   = (bus.opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (bus.annul_i) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end else if (cnt_q == CntW'(DATA_W)) begin
          result_d = {rem, quot};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end else begin
          if (diff[DATA_W]) work_d = {work_q[2*DATA_W-1:0], 1'b0};
          else              work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
        end
      end
      DivEnd: begin
        // Holding start keeps the result; a new divide needs start to drop first.
        if (bus.start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      neg_op1_q <= 1'b0;
      neg_op2_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      neg_op1_q <= neg_op1_d;
      neg_op2_q <= neg_op2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboarded bench for div_seq: expected {R,Q} queued at request, compared when ready_o rises.
module tb_div_seq;

  logic Clk;
  logic Rst_n;

  div_seq_if #(.DATA_W(32)) bus ();

  div_seq #(.DATA_W(32)) u_dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, lq, lr;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      la = {{32{a[31]}}, a};
      lb = {{32{b[31]}}, b};
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic edge1();
    @(posedge Clk);
    #1;
  endtask

  // Leaves start_i high on return; caller decides when to drop it.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
    int   cyc;
    logic stall_ok;
    int   exp_lat;
    logic [63:0] exp;
    exp_q.push_back(model(s, a, b));
    exp_lat          = (b == 32'd0) ? 1 : 33;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    #1;
    check_eq({tag, "_stall_req"}, 64'(bus.stallreq_o), 64'd1);
    cyc      = 0;
    stall_ok = 1'b1;
    while (!bus.ready_o && cyc < 100) begin
      edge1();
      cyc++;
      if (!bus.ready_o && !bus.stallreq_o) stall_ok = 1'b0;
    end
    check_eq({tag, "_latency"}, 64'(cyc - 1), 64'(exp_lat));
    check_eq({tag, "_stall_held"}, 64'(stall_ok), 64'd1);
    check_eq({tag, "_stall_drop"}, 64'(bus.stallreq_o), 64'd0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    check_eq({tag, "_result"}, bus.result_o, exp);
  endtask

  task automatic release_div(input string tag);
    bus.start_i = 1'b0;
    edge1();
    check_eq({tag, "_rel_ready"}, 64'(bus.ready_o), 64'd0);
    check_eq({tag, "_rel_result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    logic        ok;
    logic [63:0] held;

    Rst_n            = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) edge1();
    check_eq("rst_result", bus.result_o, 64'd0);
    check_eq("rst_ready", 64'(bus.ready_o), 64'd0);
    check_eq("rst_stall", 64'(bus.stallreq_o), 64'd0);
    Rst_n = 1'b1;
    edge1();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    check_eq("divu_100_7_const", bus.result_o, {32'd2, 32'd14});
    release_div("divu_100_7");

    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_m7_2_const", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    release_div("div_m7_2");

    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    check_eq("div_7_m2_const", bus.result_o, {32'd1, 32'hFFFF_FFFD});
    release_div("div_7_m2");

    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    check_eq("divu_max_1_const", bus.result_o, {32'd0, 32'hFFFF_FFFF});
    release_div("divu_max_1");

    run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
    release_div("divu_5_0");

    // Flush at step 10: start drops with annul, as ex would on a branch flush.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    edge1();
    repeat (10) edge1();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    edge1();
    bus.annul_i = 1'b0;
    check_eq("annul_ready", 64'(bus.ready_o), 64'd0);
    check_eq("annul_stall", 64'(bus.stallreq_o), 64'd0);
    ok = 1'b1;
    repeat (40) begin
      edge1();
      if (bus.ready_o) ok = 1'b0;
    end
    check_eq("annul_no_ready", 64'(ok), 64'd1);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3);
    check_eq("divu_9_3_const", bus.result_o, {32'd0, 32'd3});
    release_div("divu_9_3");

    // Reset in the middle of a divide.
    bus.opdata1_i = 32'd12345;
    bus.opdata2_i = 32'd17;
    bus.start_i   = 1'b1;
    repeat (6) edge1();
    Rst_n       = 1'b0;
    bus.start_i = 1'b0;
    edge1();
    check_eq("midrst_result", bus.result_o, 64'd0);
    check_eq("midrst_ready", 64'(bus.ready_o), 64'd0);
    check_eq("midrst_stall", 64'(bus.stallreq_o), 64'd0);
    Rst_n = 1'b1;
    edge1();
    ok = 1'b1;
    repeat (40) begin
      edge1();
      if (bus.ready_o) ok = 1'b0;
    end
    check_eq("midrst_no_ready", 64'(ok), 64'd1);

    // Start held in END: result must hold and no second divide may start.
    run_div("hold", 1'b0, 32'd77, 32'd5);
    held = bus.result_o;
    bus.opdata1_i = 32'd1;
    bus.opdata2_i = 32'd1;
    ok = 1'b1;
    repeat (40) begin
      edge1();
      if (!bus.ready_o || bus.result_o !== held) ok = 1'b0;
    end
    check_eq("hold_stable", 64'(ok), 64'd1);
    release_div("hold");

    // Back-to-back: start low for exactly one cycle, then the overflow case.
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("div_ovf_const", bus.result_o, {32'd0, 32'h8000_0000});
    release_div("div_ovf");

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      if (b == 32'd0) b = 32'd3;
      run_div($sformatf("rand%0d", i), logic'(i % 3 != 0), a, b);
      release_div($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
